// File: rtl/alu_nibble_seq_pkg.sv
// Shared ALU package: sequencer state encoding and slice width.
// Imported by the nibble sequencer and its adder slice.
package alu_nibble_seq_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_nibble_seq_add.sv
// 4-bit carry-lookahead adder slice.
// Ports: a, b, cin in; s (sum nibble), cout out.
module alu_nibble_seq_add
  import alu_nibble_seq_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              cin,
  output logic [NIBBLE-1:0] s,
  output logic              cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign s    = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/alu_nibble_seq.sv
// Multi-cycle add/sub sequencer: one nibble per cycle, LSB first.
// Ports: start_valid/ready + a, b, sub in; res_valid/ready + result, flags out.
module alu_nibble_seq
  import alu_nibble_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             sign
);

  localparam int NNIB = WIDTH / NIBBLE;
  localparam int CW   = $clog2(NNIB);
  localparam logic [CW-1:0] LAST = CW'(NNIB - 1);

  state_t                state;
  logic [WIDTH-1:0]      a_sh;
  logic [WIDTH-1:0]      b_sh;
  logic [WIDTH-1:0]      res_sh;
  logic                  carry_reg;
  logic [CW-1:0]         count;

  logic [NIBBLE-1:0]     s;
  logic                  cout;
  logic [WIDTH-1:0]      res_next;
  logic                  msb_cin;

  alu_nibble_seq_add u_add (
    .a    (a_sh[NIBBLE-1:0]),
    .b    (b_sh[NIBBLE-1:0]),
    .cin  (carry_reg),
    .s    (s),
    .cout (cout)
  );

  assign res_next    = {s, res_sh[WIDTH-1:NIBBLE]};
  // Carry into the sign bit, recovered from the sum bit.
  assign msb_cin     = a_sh[3] ^ b_sh[3] ^ s[3];
  assign start_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      carry_reg <= 1'b0;
      count     <= '0;
      res_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      sign      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_valid) begin
            a_sh      <= a;
            b_sh      <= sub ? ~b : b;
            res_sh    <= '0;
            carry_reg <= sub;
            count     <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          a_sh      <= {{NIBBLE{1'b0}}, a_sh[WIDTH-1:NIBBLE]};
          b_sh      <= {{NIBBLE{1'b0}}, b_sh[WIDTH-1:NIBBLE]};
          res_sh    <= res_next;
          carry_reg <= cout;
          count     <= count + 1'b1;
          if (count == LAST) begin
            result    <= res_next;
            carry     <= cout;
            overflow  <= msb_cin ^ cout;
            zero      <= (res_next == '0);
            sign      <= res_next[WIDTH-1];
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench for alu_nibble_seq (WIDTH = 32).
// Scenario tasks with inline comparisons; prints one summary line.
module tb_alu_nibble_seq;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] result;
  logic        carry;
  logic        overflow;
  logic        zero;
  logic        sign;

  int passed = 0;
  int total  = 0;

  alu_nibble_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .carry       (carry),
    .overflow    (overflow),
    .zero        (zero),
    .sign        (sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and wait for res_valid; lat = cycles after accept.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                        input logic isub, output int lat);
    int w;
    w = 0;
    while (!start_ready && w < 40) begin
      step();
      w++;
    end
    a = ia;
    b = ib;
    sub = isub;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'hCAFE_F00D;
    sub = ~isub;
    lat = 0;
    while (!res_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic ack();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic check_op(input string nm, input int lat,
                          input logic [31:0] er, input logic [3:0] ef);
    total++;
    if (lat !== 8)
      $display("FAIL %s latency got %0d want 8", nm, lat);
    else passed++;
    total++;
    if (result !== er)
      $display("FAIL %s result got %h want %h", nm, result, er);
    else passed++;
    total++;
    if ({carry, overflow, zero, sign} !== ef)
      $display("FAIL %s cvzs got %b want %b", nm,
               {carry, overflow, zero, sign}, ef);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_valid = 1'b0;
    res_ready = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    #12;
    total++;
    if ({res_valid, start_ready} !== 2'b01)
      $display("FAIL reset vld_rdy got %b want 01", {res_valid, start_ready});
    else passed++;
    total++;
    if (result !== 32'h0)
      $display("FAIL reset result got %h want 0", result);
    else passed++;
    total++;
    if ({carry, overflow, zero, sign} !== 4'b0000)
      $display("FAIL reset flags got %b want 0000",
               {carry, overflow, zero, sign});
    else passed++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    int lat;
    run_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, lat);
    check_op("add_wrap", lat, 32'h0000_0000, 4'b1010);
    ack();
    total++;
    if ({res_valid, start_ready} !== 2'b01)
      $display("FAIL add_ack vld_rdy got %b want 01", {res_valid, start_ready});
    else passed++;
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
    check_op("add_ovf", lat, 32'h8000_0000, 4'b0101);
    ack();
  endtask

  task automatic test_sub();
    int lat;
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, lat);
    check_op("sub_borrow", lat, 32'hFFFF_FFFE, 4'b0001);
    ack();
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, lat);
    check_op("sub_ovf", lat, 32'h7FFF_FFFF, 4'b1100);
    ack();
  endtask

  task automatic test_backpressure();
    int lat;
    logic ok;
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, lat);
    check_op("bp_first", lat, 32'h0000_0100, 4'b0000);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start_valid = i[0];
      a = 32'h5555_5555;
      b = 32'h3333_3333;
      step();
      if (!res_valid || start_ready || result !== 32'h0000_0100 ||
          {carry, overflow, zero, sign} !== 4'b0000)
        ok = 1'b0;
    end
    start_valid = 1'b0;
    total++;
    if (ok !== 1'b1)
      $display("FAIL bp_hold stable got %b want 1", ok);
    else passed++;
    ack();
    total++;
    if ({res_valid, start_ready} !== 2'b01)
      $display("FAIL bp_ack vld_rdy got %b want 01", {res_valid, start_ready});
    else passed++;
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, lat);
    check_op("bp_fresh", lat, 32'h2345_6789, 4'b0000);
    ack();
  endtask

  task automatic test_async_reset();
    int lat;
    run_op(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, lat);
    check_op("ar_pre", lat, 32'h1010_1010, 4'b0000);
    ack();
    a = 32'hAAAA_AAAA;
    b = 32'h5555_5555;
    sub = 1'b0;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({res_valid, start_ready} !== 2'b01)
      $display("FAIL ar_clear vld_rdy got %b want 01", {res_valid, start_ready});
    else passed++;
    total++;
    if (result !== 32'h0)
      $display("FAIL ar_clear result got %h want 0", result);
    else passed++;
    step();
    rst_n = 1'b1;
    step();
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
    check_op("ar_next", lat, 32'hFFFF_FFFE, 4'b1001);
    ack();
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b1, lat);
    check_op("b2b_zero", lat, 32'h0000_0000, 4'b1010);
    a = 32'hA5A5_A5A5;
    b = 32'h5A5A_5A5A;
    sub = 1'b0;
    start_valid = 1'b1;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    total++;
    if ({res_valid, start_ready} !== 2'b01)
      $display("FAIL b2b_overlap vld_rdy got %b want 01",
               {res_valid, start_ready});
    else passed++;
    step();
    start_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 20) begin
      step();
      lat++;
    end
    check_op("b2b_second", lat, 32'hFFFF_FFFF, 4'b0001);
    ack();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
